// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, FSM state type and instruction-format helpers
package cpu_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_MUL = 3'd5;
   localparam logic [2:0] OP_DIV = 3'd6;
   localparam logic [2:0] OP_MOV = 3'd7;

   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   // Payload must hold either an immediate or {rs1, rs2, op}
   function automatic int imm_w_f(input int data_w, input int reg_aw);
      return (data_w > 2 * reg_aw + 3) ? data_w : 2 * reg_aw + 3;
   endfunction

   function automatic int instr_w_f(input int data_w, input int reg_aw);
      return 1 + reg_aw + imm_w_f(data_w, reg_aw);
   endfunction

   function automatic int mode_bit_f(input int data_w, input int reg_aw);
      return instr_w_f(data_w, reg_aw) - 1;
   endfunction

endpackage

// File: rtl/cpu_muldiv.sv
// rtl/cpu_muldiv.sv - iterative shift-add multiplier / restoring divider, DATA_W iterations
module cpu_muldiv
   import cpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   input  logic              i_op_div,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic              o_last,
   output logic [DATA_W-1:0] o_result,
   output logic              o_carry,
   output logic              o_err
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   logic              r_busy;
   logic              r_div;
   logic              r_err;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;

   logic [DATA_W:0]   w_sum;
   logic [DATA_W:0]   w_rem_sh;
   logic [DATA_W-1:0] w_nxt_hi;
   logic [DATA_W-1:0] w_nxt_lo;

   // hi:lo is the product for MUL, remainder:quotient for DIV; both finish with the answer in lo
   always_comb begin
      w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      w_rem_sh = {r_hi, r_lo[DATA_W-1]};
      w_nxt_hi = '0;
      w_nxt_lo = '0;
      if (r_div) begin
         if (w_rem_sh >= {1'b0, r_b}) begin
            w_nxt_hi = DATA_W'(w_rem_sh - {1'b0, r_b});
            w_nxt_lo = {r_lo[DATA_W-2:0], 1'b1};
         end else begin
            w_nxt_hi = w_rem_sh[DATA_W-1:0];
            w_nxt_lo = {r_lo[DATA_W-2:0], 1'b0};
         end
      end else begin
         w_nxt_hi = w_sum[DATA_W:1];
         w_nxt_lo = {w_sum[0], r_lo[DATA_W-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= 1'b0;
         r_div  <= 1'b0;
         r_err  <= 1'b0;
         r_cnt  <= '0;
         r_b    <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
      end else if (i_start) begin
         r_busy <= 1'b1;
         r_div  <= i_op_div;
         r_err  <= i_op_div && (i_b == '0);
         r_cnt  <= '0;
         r_b    <= i_b;
         r_hi   <= '0;
         r_lo   <= i_a;
      end else if (r_busy) begin
         r_hi  <= w_nxt_hi;
         r_lo  <= w_nxt_lo;
         r_cnt <= r_cnt + CNT_W'(1);
         if (r_cnt == LAST_CNT)
            r_busy <= 1'b0;
      end
   end

   // Outputs reflect the iteration happening on this edge so the core can retire on it
   assign o_last   = r_busy && (r_cnt == LAST_CNT);
   assign o_result = w_nxt_lo;
   assign o_carry  = !r_div && (w_nxt_hi != '0);
   assign o_err    = r_err;

endmodule

// File: rtl/cpu_core_param.sv
// rtl/cpu_core_param.sv - parametrised register-file CPU datapath with handshake, MUL/DIV and debug port
module cpu_core_param
   import cpu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int REG_AW = 3,
   localparam int NUM_REGS = 2 ** REG_AW,
   localparam int IMM_W    = imm_w_f(DATA_W, REG_AW),
   localparam int INSTR_W  = instr_w_f(DATA_W, REG_AW)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   output logic [DATA_W-1:0]  result,
   output logic               result_valid,
   output logic               flag_zero,
   output logic               flag_carry,
   output logic               flag_err,
   input  logic [REG_AW-1:0]  dbg_addr,
   output logic [DATA_W-1:0]  dbg_data
);

   localparam int MODE_BIT = mode_bit_f(DATA_W, REG_AW);

   state_t            r_state;
   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic [REG_AW-1:0] r_rd;
   logic [DATA_W-1:0] r_result;
   logic              r_result_valid;
   logic              r_zero;
   logic              r_carry;
   logic              r_err;

   logic              w_mode;
   logic [REG_AW-1:0] w_rd;
   logic [IMM_W-1:0]  w_payload;
   logic [2:0]        w_op;
   logic [REG_AW-1:0] w_rs1;
   logic [REG_AW-1:0] w_rs2;
   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_b;
   logic              w_accept;
   logic              w_is_md;
   logic [DATA_W-1:0] w_alu_res;
   logic              w_alu_carry;
   logic              w_alu_err;
   logic              w_md_last;
   logic [DATA_W-1:0] w_md_result;
   logic              w_md_carry;
   logic              w_md_err;

   assign w_mode    = instr[MODE_BIT];
   assign w_rd      = instr[MODE_BIT-1 -: REG_AW];
   assign w_payload = instr[IMM_W-1:0];
   assign w_op      = w_payload[2:0];
   assign w_rs2     = w_payload[3 +: REG_AW];
   assign w_rs1     = w_payload[3 + REG_AW +: REG_AW];
   assign w_a       = r_regs[w_rs1];
   assign w_b       = r_regs[w_rs2];

   assign instr_ready = (r_state == ST_IDLE) && !reset;
   assign w_accept    = instr_valid && instr_ready;
   // Divide by zero never reaches the iterative unit; it retires like a single-cycle op
   assign w_is_md     = !w_mode && ((w_op == OP_MUL) || ((w_op == OP_DIV) && (w_b != '0)));

   always_comb begin
      w_alu_res   = '0;
      w_alu_carry = 1'b0;
      w_alu_err   = 1'b0;
      if (w_mode) begin
         w_alu_res = w_payload[DATA_W-1:0];
      end else begin
         case (w_op)
            OP_ADD: {w_alu_carry, w_alu_res} = {1'b0, w_a} + {1'b0, w_b};
            OP_SUB: begin
               w_alu_res   = w_a - w_b;
               w_alu_carry = (w_a < w_b);
            end
            OP_AND: w_alu_res = w_a & w_b;
            OP_OR:  w_alu_res = w_a | w_b;
            OP_XOR: w_alu_res = w_a ^ w_b;
            OP_DIV: begin
               w_alu_res = '1;
               w_alu_err = 1'b1;
            end
            OP_MOV: w_alu_res = w_a;
            default: w_alu_res = '0;
         endcase
      end
   end

   cpu_muldiv #(.DATA_W(DATA_W)) u_muldiv (
      .clk      (clk),
      .reset    (reset),
      .i_start  (w_accept && w_is_md),
      .i_op_div (w_op == OP_DIV),
      .i_a      (w_a),
      .i_b      (w_b),
      .o_last   (w_md_last),
      .o_result (w_md_result),
      .o_carry  (w_md_carry),
      .o_err    (w_md_err)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_rd           <= '0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_zero         <= 1'b0;
         r_carry        <= 1'b0;
         r_err          <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++)
            r_regs[i] <= '0;
      end else begin
         r_result_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_is_md) begin
                     r_rd    <= w_rd;
                     r_state <= ST_BUSY;
                  end else begin
                     r_regs[w_rd]   <= w_alu_res;
                     r_result       <= w_alu_res;
                     r_result_valid <= 1'b1;
                     r_zero         <= (w_alu_res == '0);
                     r_carry        <= w_alu_carry;
                     r_err          <= w_alu_err;
                  end
               end
            end
            ST_BUSY: begin
               if (w_md_last) begin
                  r_regs[r_rd]   <= w_md_result;
                  r_result       <= w_md_result;
                  r_result_valid <= 1'b1;
                  r_zero         <= (w_md_result == '0);
                  r_carry        <= w_md_carry;
                  r_err          <= w_md_err;
                  r_state        <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign result       = r_result;
   assign result_valid = r_result_valid;
   assign flag_zero    = r_zero;
   assign flag_carry   = r_carry;
   assign flag_err     = r_err;
   assign dbg_data     = r_regs[dbg_addr];

endmodule

// File: tb/tb_cpu_core_param.sv
// tb/tb_cpu_core_param.sv - directed self-checking bench for cpu_core_param at default parameters
module tb_cpu_core_param;

   localparam int DATA_W  = 8;
   localparam int REG_AW  = 3;
   localparam int INSTR_W = 13;

   logic               clk = 1'b0;
   logic               reset;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               instr_ready;
   logic [DATA_W-1:0]  result;
   logic               result_valid;
   logic               flag_zero;
   logic               flag_carry;
   logic               flag_err;
   logic [REG_AW-1:0]  dbg_addr;
   logic [DATA_W-1:0]  dbg_data;

   int n_total = 0;
   int n_bad   = 0;
   int cyc;
   logic seen_valid;

   cpu_core_param #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .result       (result),
      .result_valid (result_valid),
      .flag_zero    (flag_zero),
      .flag_carry   (flag_carry),
      .flag_err     (flag_err),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [INSTR_W-1:0] li(input logic [2:0] rd, input logic [8:0] imm);
      return {1'b1, rd, imm};
   endfunction

   function automatic logic [INSTR_W-1:0] rr(input logic [2:0] rd, input logic [2:0] rs1,
                                             input logic [2:0] rs2, input logic [2:0] op);
      return {1'b0, rd, rs1, rs2, op};
   endfunction

   task automatic send(input logic [INSTR_W-1:0] w);
      instr       = w;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
   endtask

   task automatic dbg(input string tag, input logic [2:0] a, input logic [7:0] exp);
      dbg_addr = a;
      #1;
      chk(tag, dbg_data, exp);
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!instr_ready && n < 20) begin
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset = 1'b1; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", result, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_flags", {flag_zero, flag_carry, flag_err}, 0);
      chk("rst_ready_in_reset", instr_ready, 0);
      reset = 1'b0;
      #1;
      chk("rst_ready_after", instr_ready, 1);

      send(13'b1_001_000000101);
      chk("li1_valid", result_valid, 1);
      chk("li1_result", result, 5);
      send(li(3'd2, 9'd3));
      chk("li2_valid", result_valid, 1);
      chk("li2_result", result, 3);
      dbg("dbg_r1", 3'd1, 8'd5);
      dbg("dbg_r2", 3'd2, 8'd3);
      @(posedge clk); #1;
      chk("valid_pulse", result_valid, 0);

      send(rr(3'd3, 3'd1, 3'd2, 3'd1));
      chk("sub_pos", result, 2);
      chk("sub_pos_cz", {flag_carry, flag_zero}, 2'b00);
      send(rr(3'd4, 3'd2, 3'd1, 3'd1));
      chk("sub_neg", result, 254);
      chk("sub_neg_cz", {flag_carry, flag_zero}, 2'b10);

      send(li(3'd6, 9'h1FF));
      chk("li_trunc", result, 8'hFF);
      chk("li_trunc_carry", flag_carry, 0);
      send(rr(3'd5, 3'd1, 3'd1, 3'd4));
      chk("xor_result", result, 0);
      chk("xor_zero", flag_zero, 1);

      send(li(3'd1, 9'd20));
      send(li(3'd2, 9'd13));
      send(rr(3'd3, 3'd1, 3'd2, 3'd5));
      chk("mul_accept_valid", result_valid, 0);
      wait_ready(cyc);
      chk("mul_busy_cycles", cyc, 8);
      chk("mul_valid", result_valid, 1);
      chk("mul_result", result, 4);
      chk("mul_carry", flag_carry, 1);
      dbg("dbg_r3_mul", 3'd3, 8'd4);

      send(li(3'd1, 9'd200));
      send(li(3'd2, 9'd7));
      send(rr(3'd4, 3'd1, 3'd2, 3'd6));
      wait_ready(cyc);
      chk("div_busy_cycles", cyc, 8);
      chk("div_valid", result_valid, 1);
      chk("div_result", result, 28);
      chk("div_carry", flag_carry, 0);

      send(rr(3'd5, 3'd1, 3'd0, 3'd6));
      chk("div0_valid", result_valid, 1);
      chk("div0_result", result, 255);
      chk("div0_err_carry", {flag_err, flag_carry}, 2'b10);
      chk("div0_ready", instr_ready, 1);
      send(rr(3'd6, 3'd1, 3'd2, 3'd0));
      chk("add_result", result, 207);
      chk("add_err_clear", flag_err, 0);
      send(rr(3'd6, 3'd1, 3'd1, 3'd0));
      chk("add_carry_res", result, 144);
      chk("add_carry", flag_carry, 1);
      send(rr(3'd6, 3'd1, 3'd2, 3'd2));
      chk("and_zero", {result, flag_zero}, {8'd0, 1'b1});
      send(rr(3'd6, 3'd1, 3'd2, 3'd3));
      chk("or_result", result, 207);
      send(rr(3'd7, 3'd1, 3'd0, 3'd7));
      chk("mov_result", result, 200);
      dbg("dbg_r7_mov", 3'd7, 8'd200);

      send(rr(3'd4, 3'd2, 3'd1, 3'd6));
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_valid", result_valid, 0);
      chk("abort_outs", {result, flag_zero, flag_carry, flag_err}, 0);
      reset = 1'b0;
      #1;
      chk("abort_ready", instr_ready, 1);
      seen_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (result_valid) seen_valid = 1'b1;
      end
      chk("abort_no_retire", seen_valid, 0);
      dbg("abort_rd_unchanged", 3'd4, 8'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/cpu_core_param.md
# cpu_core_param

Parametrised successor to the 8-bit `cpu` core: a register-file CPU datapath with configurable data width and register count. It adds a valid/ready instruction handshake, multi-cycle iterative MUL/DIV, result flags and a debug read port. It sits between the instruction source (testbench or future fetch unit) and whatever consumes `result`. Default parameters reproduce the existing 13-bit instruction format.

## Interface
- `DATA_W`, default 8: datapath and register width, ≥ 4.
- `REG_AW`, default 3: register address width; `NUM_REGS` = 2**`REG_AW`.
- Derived localparam `IMM_W` = max(`DATA_W`, 2·`REG_AW`+3).
- Derived localparam `INSTR_W` = 1 + `REG_AW` + `IMM_W`. Defaults give 13.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `instr`, in, `INSTR_W`: instruction word.
- `instr_valid`, in, 1: `instr` is valid this cycle.
- `instr_ready`, out, 1: core can accept an instruction.
- `result`, out, `DATA_W`: last value written to a register.
- `result_valid`, out, 1: one-cycle pulse per retired instruction.
- `flag_zero`, out, 1: `result` == 0.
- `flag_carry`, out, 1: carry/borrow/overflow of the last op.
- `flag_err`, out, 1: last op was a divide by zero.
- `dbg_addr`, in, `REG_AW`: debug register select.
- `dbg_data`, out, `DATA_W`: combinational read of `regs[dbg_addr]`.

## Operation
Instruction format is `{mode, rd, payload}`.
- `mode`=1 (immediate): `rd` ← `payload[DATA_W-1:0]`; upper payload bits are ignored. Carry=0.
- `mode`=0 (register): `payload` low bits are `{rs1, rs2, op}`, with the 3-bit `op` in bits [2:0]. Remaining upper payload bits are ignored. `rd` ← `rs1` op `rs2`.

Opcodes:
- 000 ADD: carry = carry-out.
- 001 SUB: carry = borrow (rs1 < rs2).
- 010 AND, 011 OR, 100 XOR: carry = 0.
- 101 MUL: low `DATA_W` bits of the product; carry = 1 if the high half ≠ 0. Shift-add, `DATA_W` iterations.
- 110 DIV: unsigned quotient; carry = 0. Restoring division, `DATA_W` iterations.
- 111 MOV: `rd` ← `rs1`.

Divide by zero:
- No iteration is performed.
- Quotient = all ones, `flag_err`=1, carry=0.
- Retires with single-cycle latency.

FSM states: IDLE, BUSY.
- `instr_ready` = (state==IDLE) && !`reset`.
- IDLE, accept of a single-cycle op or DIV-by-0: write `rd`, `result` and flags on the accept edge. Stay in IDLE.
- IDLE, accept of MUL/DIV: latch operands, `rd` and op; counter ← 0; go to BUSY.
- BUSY: one iteration per edge. On the `DATA_W`-th iteration edge, write `rd`, `result` and flags, then go to IDLE.
- `instr_valid` while not ready is ignored. The source must hold `instr` stable until accepted.

Reset (synchronous, `reset` high at a rising edge):
- All registers, `result`, `result_valid` and all flags ← 0. State ← IDLE.
- Reset mid-BUSY aborts the op with no register write.

## Timing
Single-cycle ops:
- Accept at edge N; `result_valid` is high in cycle N→N+1.
- `instr_ready` stays high, so throughput is 1 instruction/cycle.
- An instruction accepted at N+1 reads the value written at N. There are no hazards.

MUL/DIV:
- Accept at edge N; `instr_ready` is low from N until edge N+`DATA_W`.
- `result_valid` and `instr_ready` are high in cycle N+`DATA_W`→+1. Latency is `DATA_W` edges.
- A new instruction may be accepted at edge N+`DATA_W`+1.

Flags and `result` hold their values until the next retire. `result_valid` is high for exactly one cycle per retire.

Register file write port: one write per edge maximum.

## Structure
- Package `cpu_pkg`: opcode localparams (`OP_ADD`…`OP_MOV`), state enum, and mode bit position.
- Sub-module `cpu_muldiv`: iterative MUL/DIV unit.
  - Start and done handshake.
  - Operands, op select, counter.
  - Outputs: result, carry, err.
- Register file, decode and FSM live in `cpu_core_param`.

## Test plan
All values use defaults (`DATA_W`=8, `REG_AW`=3).
- Reset, then LI R1,5 (`1_001_000000101`) and LI R2,3 back-to-back → two `result_valid` pulses, `dbg_data`(R1)=5, R2=3.
- SUB R3=R1−R2 → `result`=2, carry=0. SUB R4=R2−R1 → 254, carry=1. Both zero=0.
- LI 9'h1FF → `result`=0xFF (truncation). XOR R5=R1^R1 → `result`=0, zero=1.
- R1=20, R2=13, MUL → `instr_ready` low for exactly 8 cycles, `result`=4, carry=1. R1=200, R2=7, DIV → 28, carry=0.
- DIV by R0=0 → retires next cycle with `result`=255, err=1. The next ADD clears err.
- Reset asserted 3 cycles into a DIV → destination register unchanged, no `result_valid`, all outputs 0. `instr_ready`=1 the cycle after reset deasserts.
